cu_fsm_dcdr: RTL
================

CU_FSM_DCDR -- requirements
Module: cu_fsm_dcdr

Interface
REQ-001 SHALL have ports: CLK  in  1  sole clock, all state changes on rising edge.
REQ-002 SHALL have port: RST  in  1  reset, synchronous and active-high.
REQ-003 SHALL have ports: ir  in  32  current instruction; br_eq, br_lt, br_ltu  in  1 each  branch-compare flags (rs1 vs rs2); intr  in  1  interrupt request; csr_mie  in  1  interrupt enable.
REQ-004 SHALL have outputs, all 1 bit: PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, csr_WE, int_taken, mret_exec.
REQ-005 SHALL have output alu_fun  4 bits  ALU operation code.
REQ-006 SHALL have output alu_srcA  1 bit: 0 = rs1, 1 = U-immediate.
REQ-007 SHALL have output alu_srcB  2 bits: 0 = rs2, 1 = I-imm, 2 = S-imm, 3 = PC.
REQ-008 SHALL have output pcSource  3 bits: 0 = PC+4, 1 = jalr, 2 = branch, 3 = jal, 4 = mtvec, 5 = mepc.
REQ-009 SHALL have output rf_wr_sel  2 bits: 0 = PC+4, 1 = CSR, 2 = memory, 3 = ALU.

Function
REQ-010 SHALL implement four states: FETCH, EXEC, WRITEBACK, INTR.
REQ-011 FETCH SHALL assert memRDEN1 only and SHALL always go to EXEC.
REQ-012 EXEC with a load (0000011) SHALL assert memRDEN2, keep PCWrite = 0, and go to WRITEBACK.
REQ-013 EXEC with any other opcode SHALL assert PCWrite; next state SHALL be INTR if (intr & csr_mie), else FETCH.
REQ-014 WRITEBACK SHALL assert regWrite, PCWrite, rf_wr_sel = 2; next state SHALL be INTR if (intr & csr_mie), else FETCH.
REQ-015 INTR SHALL assert PCWrite, int_taken, pcSource = 4 and SHALL go to FETCH; intr SHALL be ignored in FETCH and INTR.
REQ-016 regWrite in EXEC SHALL be 1 for OP, OP-IMM, LUI, AUIPC, JAL, JALR, CSRRW, and 0 for all other opcodes.
REQ-017 memWE2 SHALL be 1 only in EXEC for a store (0100011).
REQ-018 For OP (0110011), alu_fun SHALL be {ir[30], ir[14:12]}, with alu_srcA = 0, alu_srcB = 0, rf_wr_sel = 3.
REQ-019 For OP-IMM (0010011), alu_fun SHALL be {ir[30], 101} when funct3 = 101, else {0, funct3}; alu_srcB SHALL be 1.
REQ-020 LUI SHALL drive alu_fun = 1001 (pass op1) and alu_srcA = 1.
REQ-021 AUIPC SHALL drive alu_fun = 0000, alu_srcA = 1, alu_srcB = 3.
REQ-022 Loads SHALL drive alu_fun = 0000, alu_srcB = 1; stores SHALL drive alu_fun = 0000, alu_srcB = 2.
REQ-023 JAL SHALL drive pcSource = 3 and rf_wr_sel = 0.
REQ-024 JALR SHALL drive pcSource = 1 and rf_wr_sel = 0.
REQ-025 BRANCH (1100011) SHALL drive pcSource = 2 when taken, else 0; taken is defined by funct3: 000 br_eq, 001 !br_eq, 100 br_lt, 101 !br_lt, 110 br_ltu, 111 !br_ltu; funct3 010/011 SHALL be not taken.
REQ-026 SYSTEM (1110011) with funct3 = 001 SHALL assert csr_WE and regWrite in EXEC with rf_wr_sel = 1.
REQ-027 SYSTEM with funct3 = 000 SHALL assert mret_exec in EXEC with pcSource = 5.
REQ-028 An unrecognised opcode SHALL assert PCWrite with pcSource = 0 and no other strobe, i.e. it executes as a NOP.
REQ-029 Decode outputs not listed for an opcode SHALL be 0; decode outputs SHALL be combinational from state and ir, with zero-cycle latency.

Reset
REQ-030 RST high at a rising edge SHALL force state to FETCH, including mid-instruction (EXEC, WRITEBACK, INTR).
REQ-031 While RST is high, PCWrite, regWrite, memWE2, csr_WE, int_taken, mret_exec and memRDEN2 SHALL be 0.
REQ-032 After RST is released, the first cycle SHALL be FETCH with memRDEN1 = 1.

Structure
REQ-033 A shared package SHALL hold the opcode enum, the state enum, and the alu_fun, pcSource, srcA/B and rf_wr_sel constants.
REQ-034 The combinational decoder SHALL be a sub-module cu_dcdr; the state register and transitions SHALL live in cu_fsm_dcdr.

Verification
REQ-035 Reset, then release -> FETCH, memRDEN1 = 1; the next cycle is EXEC.
REQ-036 ir = 0x40208033 (sub) in EXEC -> alu_fun = 1000, regWrite = 1, rf_wr_sel = 3, PCWrite = 1.
REQ-037 ir = 0x0000A103 (lw) -> EXEC has memRDEN2 = 1, PCWrite = 0; WRITEBACK has regWrite = 1, rf_wr_sel = 2.
REQ-038 ir = 0x00208463 (beq): br_eq = 1 -> pcSource = 2; br_eq = 0 -> pcSource = 0.
REQ-039 ir = 0x123452B7 (lui) -> alu_fun = 1001, alu_srcA = 1; intr = csr_mie = 1 in EXEC -> next state INTR with int_taken = 1, pcSource = 4.
REQ-040 RST asserted in WRITEBACK -> regWrite = 0 in that cycle and state = FETCH at the next edge.

Source files
------------

// File: rtl/cu_fsm_dcdr_pkg.sv
// cu_fsm_dcdr_pkg: shared opcodes, states, control encodings and decode bundle
package cu_fsm_dcdr_pkg;

   typedef enum logic [6:0] {
      OP_LOAD   = 7'b0000011,
      OP_IMM    = 7'b0010011,
      OP_AUIPC  = 7'b0010111,
      OP_STORE  = 7'b0100011,
      OP_OP     = 7'b0110011,
      OP_LUI    = 7'b0110111,
      OP_BRANCH = 7'b1100011,
      OP_JALR   = 7'b1100111,
      OP_JAL    = 7'b1101111,
      OP_SYS    = 7'b1110011
   } opcode_t;

   typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_WB, ST_INTR} state_t;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_LUI = 4'b1001;

   localparam logic SRCA_RS1  = 1'b0;
   localparam logic SRCA_UIMM = 1'b1;

   localparam logic [1:0] SRCB_RS2  = 2'd0;
   localparam logic [1:0] SRCB_IIMM = 2'd1;
   localparam logic [1:0] SRCB_SIMM = 2'd2;
   localparam logic [1:0] SRCB_PC   = 2'd3;

   localparam logic [2:0] PC_NEXT  = 3'd0;
   localparam logic [2:0] PC_JALR  = 3'd1;
   localparam logic [2:0] PC_BR    = 3'd2;
   localparam logic [2:0] PC_JAL   = 3'd3;
   localparam logic [2:0] PC_MTVEC = 3'd4;
   localparam logic [2:0] PC_MEPC  = 3'd5;

   localparam logic [1:0] WR_PC4 = 2'd0;
   localparam logic [1:0] WR_CSR = 2'd1;
   localparam logic [1:0] WR_MEM = 2'd2;
   localparam logic [1:0] WR_ALU = 2'd3;

   typedef struct packed {
      logic       pc_write;
      logic       reg_write;
      logic       mem_we2;
      logic       mem_rden1;
      logic       mem_rden2;
      logic       csr_we;
      logic       int_taken;
      logic       mret_exec;
      logic [3:0] alu_fun;
      logic       alu_srca;
      logic [1:0] alu_srcb;
      logic [2:0] pc_source;
      logic [1:0] rf_wr_sel;
   } ctrl_t;

   // funct3[0] inverts the base condition; 010/011 have no condition and never branch
   function automatic logic br_taken(input logic [2:0] f3, input logic eq, input logic lt, input logic ltu);
      return f3[2] ? ((f3[1] ? ltu : lt) ^ f3[0]) : (f3[1] ? 1'b0 : (eq ^ f3[0]));
   endfunction

endpackage

// File: rtl/cu_fsm_dcdr_if.sv
// cu_fsm_dcdr_if: instruction/flag inputs and control outputs of the control unit
interface cu_fsm_dcdr_if;
   logic [31:0] ir;
   logic        br_eq, br_lt, br_ltu, intr, csr_mie;
   logic        PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, csr_WE, int_taken, mret_exec;
   logic [3:0]  alu_fun;
   logic        alu_srcA;
   logic [1:0]  alu_srcB;
   logic [2:0]  pcSource;
   logic [1:0]  rf_wr_sel;

   modport master (
      output ir, br_eq, br_lt, br_ltu, intr, csr_mie,
      input  PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, csr_WE, int_taken, mret_exec,
      input  alu_fun, alu_srcA, alu_srcB, pcSource, rf_wr_sel
   );

   modport slave (
      input  ir, br_eq, br_lt, br_ltu, intr, csr_mie,
      output PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, csr_WE, int_taken, mret_exec,
      output alu_fun, alu_srcA, alu_srcB, pcSource, rf_wr_sel
   );
endinterface

// File: rtl/cu_fsm_dcdr_dcdr.sv
// cu_dcdr: combinational control decode from FSM state and instruction fields
module cu_dcdr
   import cu_fsm_dcdr_pkg::*;
(
   input  state_t     state_i,
   input  logic [6:0] opcode_i,
   input  logic [2:0] funct3_i,
   input  logic       ir30_i,
   input  logic       br_eq_i,
   input  logic       br_lt_i,
   input  logic       br_ltu_i,
   output ctrl_t      ctrl_o
);

   opcode_t op;
   assign op = opcode_t'(opcode_i);

   // per-state strobes; in EXEC every opcode except a load advances the PC
   always_comb begin
      ctrl_o = '0;
      case (state_i)
         ST_FETCH: ctrl_o.mem_rden1 = 1'b1;
         ST_WB: begin
            ctrl_o.pc_write  = 1'b1;
            ctrl_o.reg_write = 1'b1;
            ctrl_o.rf_wr_sel = WR_MEM;
         end
         ST_INTR: begin
            ctrl_o.pc_write  = 1'b1;
            ctrl_o.int_taken = 1'b1;
            ctrl_o.pc_source = PC_MTVEC;
         end
         ST_EXEC: begin
            ctrl_o.pc_write = 1'b1;
            case (op)
               OP_LOAD: begin
                  ctrl_o.pc_write  = 1'b0;
                  ctrl_o.mem_rden2 = 1'b1;
                  ctrl_o.alu_fun   = ALU_ADD;
                  ctrl_o.alu_srcb  = SRCB_IIMM;
               end
               OP_STORE: begin
                  ctrl_o.mem_we2  = 1'b1;
                  ctrl_o.alu_fun  = ALU_ADD;
                  ctrl_o.alu_srcb = SRCB_SIMM;
               end
               OP_OP: begin
                  ctrl_o.reg_write = 1'b1;
                  ctrl_o.alu_fun   = {ir30_i, funct3_i};
                  ctrl_o.alu_srca  = SRCA_RS1;
                  ctrl_o.alu_srcb  = SRCB_RS2;
                  ctrl_o.rf_wr_sel = WR_ALU;
               end
               OP_IMM: begin
                  ctrl_o.reg_write = 1'b1;
                  ctrl_o.alu_fun   = funct3_i == 3'b101 ? {ir30_i, funct3_i} : {1'b0, funct3_i};
                  ctrl_o.alu_srcb  = SRCB_IIMM;
                  ctrl_o.rf_wr_sel = WR_ALU;
               end
               OP_LUI: begin
                  ctrl_o.reg_write = 1'b1;
                  ctrl_o.alu_fun   = ALU_LUI;
                  ctrl_o.alu_srca  = SRCA_UIMM;
                  ctrl_o.rf_wr_sel = WR_ALU;
               end
               OP_AUIPC: begin
                  ctrl_o.reg_write = 1'b1;
                  ctrl_o.alu_fun   = ALU_ADD;
                  ctrl_o.alu_srca  = SRCA_UIMM;
                  ctrl_o.alu_srcb  = SRCB_PC;
                  ctrl_o.rf_wr_sel = WR_ALU;
               end
               OP_JAL: begin
                  ctrl_o.reg_write = 1'b1;
                  ctrl_o.pc_source = PC_JAL;
                  ctrl_o.rf_wr_sel = WR_PC4;
               end
               OP_JALR: begin
                  ctrl_o.reg_write = 1'b1;
                  ctrl_o.pc_source = PC_JALR;
                  ctrl_o.rf_wr_sel = WR_PC4;
               end
               OP_BRANCH: ctrl_o.pc_source = br_taken(funct3_i, br_eq_i, br_lt_i, br_ltu_i) ? PC_BR : PC_NEXT;
               OP_SYS: begin
                  ctrl_o.csr_we    = funct3_i == 3'b001;
                  ctrl_o.reg_write = funct3_i == 3'b001;
                  ctrl_o.rf_wr_sel = funct3_i == 3'b001 ? WR_CSR : WR_PC4;
                  ctrl_o.mret_exec = funct3_i == 3'b000;
                  ctrl_o.pc_source = funct3_i == 3'b000 ? PC_MEPC : PC_NEXT;
               end
               default: ;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/cu_fsm_dcdr.sv
// cu_fsm_dcdr: multi-cycle control unit FSM (fetch/exec/writeback/interrupt)
module cu_fsm_dcdr
   import cu_fsm_dcdr_pkg::*;
(
   input  logic         CLK,
   input  logic         RST,
   cu_fsm_dcdr_if.slave bus
);

   state_t state_q;
   ctrl_t  ctrl;
   logic   irq;

   assign irq = bus.intr & bus.csr_mie;

   cu_dcdr u_dcdr (
      .state_i  (state_q),
      .opcode_i (bus.ir[6:0]),
      .funct3_i (bus.ir[14:12]),
      .ir30_i   (bus.ir[30]),
      .br_eq_i  (bus.br_eq),
      .br_lt_i  (bus.br_lt),
      .br_ltu_i (bus.br_ltu),
      .ctrl_o   (ctrl)
   );

   // state register; interrupts are only taken at instruction boundaries (end of EXEC/WB)
   always_ff @(posedge CLK) begin
      if (RST) state_q <= ST_FETCH;
      else
         case (state_q)
            ST_FETCH: state_q <= ST_EXEC;
            ST_EXEC:  state_q <= ctrl.mem_rden2 ? ST_WB : (irq ? ST_INTR : ST_FETCH);
            ST_WB:    state_q <= irq ? ST_INTR : ST_FETCH;
            ST_INTR:  state_q <= ST_FETCH;
         endcase
   end

   // side-effecting strobes are suppressed during reset so a mid-instruction reset commits nothing
   assign bus.PCWrite   = ctrl.pc_write  & ~RST;
   assign bus.regWrite  = ctrl.reg_write & ~RST;
   assign bus.memWE2    = ctrl.mem_we2   & ~RST;
   assign bus.memRDEN2  = ctrl.mem_rden2 & ~RST;
   assign bus.csr_WE    = ctrl.csr_we    & ~RST;
   assign bus.int_taken = ctrl.int_taken & ~RST;
   assign bus.mret_exec = ctrl.mret_exec & ~RST;
   assign bus.memRDEN1  = ctrl.mem_rden1;
   assign bus.alu_fun   = ctrl.alu_fun;
   assign bus.alu_srcA  = ctrl.alu_srca;
   assign bus.alu_srcB  = ctrl.alu_srcb;
   assign bus.pcSource  = ctrl.pc_source;
   assign bus.rf_wr_sel = ctrl.rf_wr_sel;

endmodule
